// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter: per grant it strobes the bus register clear, then load,
// then holds the grant until the owner releases it or the hold limit is reached.
module bus_arbiter #(
  parameter int N        = 4,
  parameter int HOLD_MAX = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         rel,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] owner,
  output logic                 busy,
  output logic                 bus_clr,
  output logic                 bus_load,
  output logic                 timeout
);

  localparam int OW = $clog2(N);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  typedef enum logic [1:0] {IDLE, CLR, LOAD, HOLD} state_t;

  state_t        state;
  logic [OW-1:0] last;
  logic [OW-1:0] win;
  logic [7:0]    cnt;

  // Scan from the farthest candidate to the nearest so the nearest set bit after last wins.
  function automatic logic [OW-1:0] rr_pick(input logic [N-1:0] r, input logic [OW-1:0] l);
    logic [OW-1:0] w;
    int            idx;
    w = l;
    for (int i = N; i >= 1; i--) begin
      idx = (int'(l) + i) % N;
      if (r[idx]) w = idx[OW-1:0];
    end
    return w;
  endfunction

  assign win = rr_pick(req, last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      owner   <= '0;
      last    <= OW'(N - 1);
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            owner <= win;
            last  <= win;
            state <= CLR;
          end
        end
        CLR:  state <= LOAD;
        LOAD: begin
          state <= HOLD;
          cnt   <= '0;
        end
        HOLD: begin
          // Release wins over the hold limit when both occur on the same edge.
          if (rel[owner] || !req[owner]) begin
            state <= IDLE;
          end else if (cnt == HOLD_LAST) begin
            state   <= IDLE;
            timeout <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    gnt = '0;
    if (state == LOAD || state == HOLD) gnt[owner] = 1'b1;
  end

  assign busy     = (state != IDLE);
  assign bus_clr  = (state == CLR);
  assign bus_load = (state == LOAD);

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed testbench for bus_arbiter (N=4, HOLD_MAX=15).
module tb_bus_arbiter;

  localparam int N        = 4;
  localparam int HOLD_MAX = 15;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] rel = '0;
  logic [N-1:0] gnt;
  logic [1:0]   owner;
  logic         busy, bus_clr, bus_load, timeout;

  int n_checks = 0;
  int n_fail   = 0;

  bus_arbiter #(.N(N), .HOLD_MAX(HOLD_MAX)) dut (
    .clk(clk), .rst(rst), .req(req), .rel(rel), .gnt(gnt), .owner(owner),
    .busy(busy), .bus_clr(bus_clr), .bus_load(bus_load), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    req = '0;
    rel = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Advance negedges until bus_load is seen; ok=0 if the budget runs out.
  task automatic wait_load(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (bus_load) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({gnt, owner, busy, bus_clr, bus_load, timeout} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got gnt=%b owner=%0d busy=%b clr=%b load=%b to=%b, want all 0",
               gnt, owner, busy, bus_clr, bus_load, timeout);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    req = 4'b0001;
    @(negedge clk);
    n_checks++;
    if ({bus_clr, bus_load, gnt, busy, owner} !== {1'b1, 1'b0, 4'b0000, 1'b1, 2'd0}) begin
      n_fail++;
      $display("FAIL single_clr: got clr=%b load=%b gnt=%b busy=%b owner=%0d, want 1 0 0000 1 0",
               bus_clr, bus_load, gnt, busy, owner);
    end
    @(negedge clk);
    n_checks++;
    if ({bus_clr, bus_load, gnt} !== {1'b0, 1'b1, 4'b0001}) begin
      n_fail++;
      $display("FAIL single_load: got clr=%b load=%b gnt=%b, want 0 1 0001", bus_clr, bus_load, gnt);
    end
    @(negedge clk);
    n_checks++;
    if ({bus_load, gnt, busy} !== {1'b0, 4'b0001, 1'b1}) begin
      n_fail++;
      $display("FAIL single_hold: got load=%b gnt=%b busy=%b, want 0 0001 1", bus_load, gnt, busy);
    end
    rel = 4'b0001;
    @(negedge clk);
    rel = '0;
    req = '0;
    n_checks++;
    if ({gnt, busy, timeout} !== {4'b0000, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL single_release: got gnt=%b busy=%b to=%b, want 0000 0 0", gnt, busy, timeout);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int exp_order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_load(ok);
      n_checks++;
      if (!ok || owner !== 2'(exp_order[g]) || gnt !== 4'(1 << exp_order[g])) begin
        n_fail++;
        $display("FAIL rr_grant%0d: got ok=%b owner=%0d gnt=%b, want owner=%0d", g, ok, owner, gnt,
                 exp_order[g]);
      end
      for (int h = 0; h < 2; h++) begin
        @(negedge clk);
        n_checks++;
        if (!$onehot(gnt) || (bus_clr && bus_load)) begin
          n_fail++;
          $display("FAIL rr_hold%0d_%0d: got gnt=%b clr=%b load=%b, want one-hot gnt, no strobe overlap",
                   g, h, gnt, bus_clr, bus_load);
        end
      end
      rel = gnt;
      @(negedge clk);
      rel = '0;
    end
    req = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_timeout();
    bit ok;
    int width;
    bit early_to;
    do_reset();
    req = 4'b0100;
    wait_load(ok);
    width = 0;
    early_to = 1'b0;
    for (int i = 0; i < 40 && gnt != 0; i++) begin
      width++;
      if (timeout) early_to = 1'b1;
      @(negedge clk);
    end
    req = '0;
    n_checks++;
    if (!ok || width != HOLD_MAX + 1 || early_to) begin
      n_fail++;
      $display("FAIL timeout_width: got ok=%b width=%0d early=%b, want 1 %0d 0", ok, width, early_to,
               HOLD_MAX + 1);
    end
    n_checks++;
    if ({timeout, owner, busy} !== {1'b1, 2'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL timeout_pulse: got to=%b owner=%0d busy=%b, want 1 2 0", timeout, owner, busy);
    end
    @(negedge clk);
    n_checks++;
    if (timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_single_cycle: got to=%b, want 0", timeout);
    end
  endtask

  task automatic test_release_vs_timeout();
    bit ok;
    req = 4'b0010;
    wait_load(ok);
    repeat (HOLD_MAX) @(negedge clk);
    n_checks++;
    if (!ok || gnt !== 4'b0010) begin
      n_fail++;
      $display("FAIL same_edge_last_hold: got ok=%b gnt=%b, want 1 0010", ok, gnt);
    end
    rel = 4'b0010;
    @(negedge clk);
    rel = '0;
    req = '0;
    n_checks++;
    if ({gnt, busy, timeout} !== {4'b0000, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL same_edge_exit: got gnt=%b busy=%b to=%b, want 0000 0 0", gnt, busy, timeout);
    end
  endtask

  task automatic test_nonowner_and_drop();
    bit ok;
    int width;
    req = 4'b0010;
    wait_load(ok);
    @(negedge clk);
    rel = 4'b0001;
    @(negedge clk);
    rel = '0;
    n_checks++;
    if (!ok || gnt !== 4'b0010 || owner !== 2'd1) begin
      n_fail++;
      $display("FAIL nonowner_rel: got ok=%b gnt=%b owner=%0d, want 1 0010 1", ok, gnt, owner);
    end
    rel = 4'b0010;
    @(negedge clk);
    rel = '0;
    req = 4'b0010;
    @(negedge clk);
    n_checks++;
    if (bus_clr !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_clr: got clr=%b, want 1", bus_clr);
    end
    req = '0;
    width = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (gnt == 4'b0010) width++;
    end
    n_checks++;
    if (width != 2 || timeout !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_width: got width=%0d to=%b busy=%b, want 2 0 0", width, timeout, busy);
    end
  endtask

  task automatic test_reset_mid_hold();
    bit ok;
    req = 4'b0100;
    wait_load(ok);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({gnt, busy, bus_clr, bus_load, timeout, owner} !== 10'b0) begin
      n_fail++;
      $display("FAIL async_reset: got gnt=%b busy=%b clr=%b load=%b to=%b owner=%0d, want all 0",
               gnt, busy, bus_clr, bus_load, timeout, owner);
    end
    @(negedge clk);
    rst = 1'b0;
    req = 4'b1001;
    @(negedge clk);
    n_checks++;
    if ({bus_clr, owner} !== {1'b1, 2'd0}) begin
      n_fail++;
      $display("FAIL post_reset_winner: got clr=%b owner=%0d, want 1 0", bus_clr, owner);
    end
    @(negedge clk);
    n_checks++;
    if (gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL post_reset_gnt: got gnt=%b, want 0001", gnt);
    end
    req = '0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_release_vs_timeout();
    test_nonowner_and_drop();
    test_reset_mid_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
